i2c_target: RTL

I2C target (responder) that is the far end of the bus driven by the team's I2C controller: it detects START/STOP, matches a 7-bit address, and acknowledges it. It then serves a four-byte register file through pointer-plus-data writes and auto-incrementing reads. It runs on the fabric clock. It connects to the pads in open-drain form: `sda_out` = 1 releases the line, `sda_out` = 0 pulls it low. This lets it sit on GPIO pins beside the controller for loopback testing on the board.

---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_line_sync.sv | 36 +++
 rtl/i2c_target.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding (common with the controller's
// debug view) and bus-level bit constants.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ADDR_ACK = 4'd2,
    ST_PTR      = 4'd3,
    ST_RX_BYTE  = 4'd4,
    ST_RX_ACK   = 4'd5,
    ST_TX_BYTE  = 4'd6,
    ST_TX_ACK   = 4'd7,
    ST_IGNORE   = 4'd8
  } i2c_state_e;

  localparam logic       BIT_ACK       = 1'b0;
  localparam logic       BIT_NACK      = 1'b1;
  localparam logic       RW_WRITE      = 1'b0;
  localparam logic       RW_READ       = 1'b1;
  localparam logic       SDA_RELEASE   = 1'b1;
  localparam logic [3:0] BITS_PER_BYTE = 4'd8;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizers plus history flops for SCL/SDA; produces SCL edge
// pulses and START/STOP detection from the synchronized and history levels.
module i2c_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // [0] first sync flop, [1] synchronized level, [2] history
  logic [2:0] scl_p;
  logic [2:0] sda_p;

  // Reset to the idle-bus level so no edge is reported coming out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_p <= '1;
      sda_p <= '1;
    end else begin
      scl_p <= {scl_p[1:0], scl_in};
      sda_p <= {sda_p[1:0], sda_in};
    end
  end

  assign sda       = sda_p[1];
  assign scl_rise  =  scl_p[1] & ~scl_p[2];
  assign scl_fall  = ~scl_p[1] &  scl_p[2];
  assign start_det =  scl_p[1] &  scl_p[2] &  sda_p[2] & ~sda_p[1];
  assign stop_det  =  scl_p[1] &  scl_p[2] & ~sda_p[2] &  sda_p[1];

endmodule

// File: rtl/i2c_target.sv
// I2C target serving a four-byte register file: pointer-then-data writes,
// auto-incrementing reads, open-drain SDA request, no clock stretching.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h3C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_out,
  output logic [31:0] regs,
  output logic        rx_strobe,
  output logic        busy,
  output logic [3:0]  state
);

  logic sda_sync, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda       (sda_sync),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  sr_q, sr_d;
  logic        sda_q, sda_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [31:0] regs_q, regs_d;
  logic        strobe_q, strobe_d;
  logic        busy_q, busy_d;
  logic [7:0]  cur_byte;

  assign cur_byte = regs_q[{ptr_q, 3'b000} +: 8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sr_q     <= '0;
      sda_q    <= SDA_RELEASE;
      ptr_q    <= '0;
      regs_q   <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      sda_q    <= sda_d;
      ptr_q    <= ptr_d;
      regs_q   <= regs_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    sda_d    = sda_q;
    ptr_d    = ptr_q;
    regs_d   = regs_q;
    strobe_d = 1'b0;
    busy_d   = busy_q;

    if (stop_det) begin
      state_d = ST_IDLE;
      sda_d   = SDA_RELEASE;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else if (start_det) begin
      state_d = ST_ADDR;
      sda_d   = SDA_RELEASE;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: ;

        // Receive states share the shifter; the completed byte is acted on at
        // the SCL fall that opens its ACK slot, so the ACK drive, regfile write
        // and strobe all land in the same clk.
        ST_ADDR, ST_PTR, ST_RX_BYTE: begin
          if (scl_rise && cnt_q != BITS_PER_BYTE) begin
            sr_d  = {sr_q[6:0], sda_sync};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == BITS_PER_BYTE) begin
            cnt_d = '0;
            if (state_q == ST_ADDR) begin
              if (sr_q[7:1] == TARGET_ADDR && sr_q[7:1] != 7'd0) begin
                state_d = ST_ADDR_ACK;
                sda_d   = BIT_ACK;
                busy_d  = 1'b1;
              end else begin
                state_d = ST_IGNORE;
              end
            end else begin
              if (state_q == ST_PTR) begin
                ptr_d = sr_q[1:0];
              end else begin
                regs_d[{ptr_q, 3'b000} +: 8] = sr_q;
                strobe_d = 1'b1;
                ptr_d    = ptr_q + 2'd1;
              end
              state_d = ST_RX_ACK;
              sda_d   = BIT_ACK;
            end
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = '0;
            if (sr_q[0] == RW_WRITE) begin
              state_d = ST_PTR;
              sda_d   = SDA_RELEASE;
            end else begin
              state_d = ST_TX_BYTE;
              sda_d   = cur_byte[7];
              sr_d    = {cur_byte[6:0], 1'b0};
            end
          end
        end

        ST_RX_ACK: begin
          if (scl_fall) begin
            state_d = ST_RX_BYTE;
            sda_d   = SDA_RELEASE;
            cnt_d   = '0;
          end
        end

        ST_TX_BYTE: begin
          if (scl_rise && cnt_q != BITS_PER_BYTE) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == BITS_PER_BYTE) begin
              state_d = ST_TX_ACK;
              sda_d   = SDA_RELEASE;
              cnt_d   = '0;
            end else begin
              sda_d = sr_q[7];
              sr_d  = {sr_q[6:0], 1'b0};
            end
          end
        end

        // cnt marks that an ACK was seen; the next byte loads on the following fall
        ST_TX_ACK: begin
          if (scl_rise && cnt_q == 4'd0) begin
            if (sda_sync == BIT_NACK) begin
              state_d = ST_IGNORE;
              busy_d  = 1'b0;
            end else begin
              ptr_d = ptr_q + 2'd1;
              cnt_d = 4'd1;
            end
          end else if (scl_fall && cnt_q == 4'd1) begin
            state_d = ST_TX_BYTE;
            sda_d   = cur_byte[7];
            sr_d    = {cur_byte[6:0], 1'b0};
            cnt_d   = '0;
          end
        end

        ST_IGNORE: sda_d = SDA_RELEASE;

        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign sda_out   = sda_q;
  assign regs      = regs_q;
  assign rx_strobe = strobe_q;
  assign busy      = busy_q;
  assign state     = state_q;

endmodule
